start_busy_fsm: RTL and testbench

//  Parametrised start/busy controller, next generation of the IDLE/ACTIVE busy FSM.
//  A start request launches an ACTIVE window of programmable length, with busy held high

---
 rtl/start_busy_pkg.sv | 16 +
 rtl/start_busy_fsm_load_down_counter.sv | 26 ++
 rtl/start_busy_fsm.sv | 97 +++++++++
 tb/tb_start_busy_fsm.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/start_busy_pkg.sv
// Shared state encoding for the start/busy controller and its bench.
package start_busy_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] S_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] S_ACTIVE = 2'd1;
  localparam logic [STATE_W-1:0] S_DONE   = 2'd2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = S_IDLE,
    ACTIVE = S_ACTIVE,
    DONE   = S_DONE
  } state_e;

endpackage

// File: rtl/start_busy_fsm_load_down_counter.sv
// Loadable down counter holding the cycles left in the active window.
module load_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] q,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (dec && !zero) begin
      q <= q - W'(1);
    end
  end

  assign zero = (q == '0);

endmodule

// File: rtl/start_busy_fsm.sv
// Start/busy window controller: timed busy window ending in a done or aborted pulse.
// Optional START_BUSY_RETRIGGER_EN: start during ACTIVE reloads the window length.
module start_busy_fsm
  import start_busy_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   len,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [CNT_W-1:0]   remaining,
  output logic [STATE_W-1:0] state_o
);

  state_e             state_p0;
  state_e             state_nxt;
  logic               cnt_load;
  logic               cnt_dec;
  logic               cnt_zero;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_load_val;

  // A zero length still yields one busy cycle, so both 0 and 1 load a count of 0.
  function automatic logic [CNT_W-1:0] len_to_cnt(input logic [CNT_W-1:0] l);
    return (l == '0) ? '0 : l - CNT_W'(1);
  endfunction

  assign cnt_load_val = len_to_cnt(len);

  load_down_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .q        (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p0 <= IDLE;
      aborted  <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      aborted  <= (state_p0 == ACTIVE) && abort;
    end
  end

  always_comb begin
    state_nxt = state_p0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state_p0)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = ACTIVE;
          cnt_load  = 1'b1;
        end
      end
      ACTIVE: begin
        // Abort outranks both a reload and the terminal count.
        if (abort) begin
          state_nxt = IDLE;
`ifdef START_BUSY_RETRIGGER_EN
        end else if (start) begin
          cnt_load  = 1'b1;
`endif
        end else if (cnt_zero) begin
          state_nxt = DONE;
        end else begin
          cnt_dec   = 1'b1;
        end
      end
      DONE: begin
        if (start && !abort) begin
          state_nxt = ACTIVE;
          cnt_load  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state_p0 == ACTIVE);
  assign done      = (state_p0 == DONE);
  assign state_o   = state_p0;
  assign remaining = busy ? cnt + CNT_W'(1) : '0;

endmodule

// File: tb/tb_start_busy_fsm.sv
// Directed plus random bench for start_busy_fsm against a cycle-count reference model.
module tb_start_busy_fsm;
  import start_busy_pkg::*;

  localparam int CNT_W = 8;

  logic               clk;
  logic               rst;
  logic               start;
  logic               abort;
  logic [CNT_W-1:0]   len;
  logic               busy;
  logic               done;
  logic               aborted;
  logic [CNT_W-1:0]   remaining;
  logic [STATE_W-1:0] state_o;

  int n_tests;
  int n_fail;

  // Reference: m_rem = busy cycles left including the current one (0 = not busy).
  int m_rem;
  int m_dn;
  int m_ab;

  start_busy_fsm #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .remaining (remaining),
    .state_o   (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int exp_state;
    exp_state = (m_rem > 0) ? int'(S_ACTIVE) : (m_dn != 0) ? int'(S_DONE) : int'(S_IDLE);
    check({tag, ".busy"},      int'(busy),      int'(m_rem > 0));
    check({tag, ".done"},      int'(done),      m_dn);
    check({tag, ".aborted"},   int'(aborted),   m_ab);
    check({tag, ".remaining"}, int'(remaining), m_rem);
    check({tag, ".state_o"},   int'(state_o),   exp_state);
    check({tag, ".busy_and_done"}, int'(busy & done), 0);
  endtask

  function automatic void model_reset();
    m_rem = 0;
    m_dn  = 0;
    m_ab  = 0;
  endfunction

  function automatic void model_edge(input int s, input int a, input int l);
    int leff;
    leff = (l == 0) ? 1 : l;
    if (m_rem > 0) begin
      m_dn = 0;
      m_ab = 0;
      if (a != 0) begin
        m_rem = 0;
        m_ab  = 1;
`ifdef START_BUSY_RETRIGGER_EN
      end else if (s != 0) begin
        m_rem = leff;
`endif
      end else if (m_rem == 1) begin
        m_rem = 0;
        m_dn  = 1;
      end else begin
        m_rem = m_rem - 1;
      end
    end else begin
      m_dn = 0;
      m_ab = 0;
      if (s != 0 && a == 0) m_rem = leff;
    end
  endfunction

  // Drive inputs just after an edge, clock once, then check outputs 1 time unit after the edge.
  task automatic step(input string tag, input int s, input int a, input int l);
    start = s[0];
    abort = a[0];
    len   = CNT_W'(l);
    @(posedge clk);
    model_edge(s, a, l);
    #1;
    check_all(tag);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    len   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b1;
    step("idle", 0, 0, 0);

    // Basic window, len changed mid-window has no effect
    step("basic", 1, 0, 4);
    step("basic", 0, 0, 4);
    step("basic", 0, 0, 9);
    repeat (4) step("basic", 0, 0, 4);

    // Zero and unit length
    step("len0", 1, 0, 0);
    repeat (3) step("len0", 0, 0, 0);
    step("len1", 1, 0, 1);
    repeat (3) step("len1", 0, 0, 1);

    // Back-to-back with start held high
    repeat (9) step("b2b", 1, 0, 3);
    repeat (4) step("b2b", 0, 0, 3);

    // Abort on 3rd busy cycle, then start&abort together in IDLE
    step("abort", 1, 0, 10);
    step("abort", 0, 0, 10);
    step("abort", 0, 0, 10);
    step("abort", 0, 1, 10);
    repeat (2) step("abort", 0, 0, 10);
    step("st_ab", 1, 1, 7);
    step("st_ab", 0, 0, 7);

    // Abort on the terminal-count cycle
    step("abort_tc", 1, 0, 2);
    step("abort_tc", 0, 0, 2);
    step("abort_tc", 0, 1, 2);
    repeat (2) step("abort_tc", 0, 0, 2);

    // Second start on 3rd busy cycle (retrigger or ignored depending on build)
    step("retrig", 1, 0, 5);
    step("retrig", 0, 0, 5);
    step("retrig", 0, 0, 5);
    step("retrig", 1, 0, 2);
    repeat (6) step("retrig", 0, 0, 2);

    // Asynchronous reset mid-window with cnt=5 (remaining=6)
    step("rst_mid", 1, 0, 10);
    repeat (4) step("rst_mid", 0, 0, 10);
    check("rst_mid.pre_remaining", int'(remaining), 6);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_held");
    rst = 1'b1;
    step("post_rst", 0, 0, 10);
    step("post_rst", 1, 0, 2);
    repeat (3) step("post_rst", 0, 0, 2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      int s, a, l;
      s = ($urandom_range(0, 2) == 0) ? 1 : 0;
      a = ($urandom_range(0, 7) == 0) ? 1 : 0;
      l = ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(0, 7));
      step("rand", s, a, l);
    end
    repeat (300) step("drain", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
